// File: rtl/memory_access_stage.sv
// MEM stage: data-memory req/ready master, store lane formatting, load extension, MEM/WB register.
// Same-cycle completion when ready is high; otherwise StallM holds upstream until ready or timeout.
module memory_access_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RdM,
    input  logic [31:0] PCPlus4M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [4:0]  RdW,
    output logic [31:0] PCPlus4W,
    output logic        MisalignW,
    output logic        BusErrW
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic {StIdle, StWait} state_t;

    state_t        state;
    logic [CW-1:0] waitCnt;
    logic [31:0]   latAddr;
    logic [31:0]   latWdata;
    logic          latWe;
    logic [3:0]    latBe;
    logic [2:0]    latFunct3;

    logic          isAccess;
    logic          isMisaligned;
    logic          misalignNow;
    logic          startAccess;
    logic          busActive;
    logic          timeoutHit;
    logic          stall;
    logic [31:0]   fmtWdata;
    logic [3:0]    fmtBe;
    logic [1:0]    laneSel;
    logic [2:0]    curFunct3;
    logic [31:0]   laneData;
    logic [31:0]   loadExt;

    assign isAccess = (ResultSrcM == 2'b01) || MemWriteM;

    always_comb begin
        isMisaligned = 1'b0;
        case (Funct3M[1:0])
            2'b01:   isMisaligned = ALUResultM[0];
            2'b10:   isMisaligned = |ALUResultM[1:0];
            default: isMisaligned = 1'b0;
        endcase
    end

    assign misalignNow = (state == StIdle) && isAccess && isMisaligned;
    assign startAccess = (state == StIdle) && isAccess && !isMisaligned;
    assign busActive   = startAccess || (state == StWait);
    // Ready in the final counted cycle takes priority over the abort.
    assign timeoutHit  = (TIMEOUT_CYCLES != 0) && (state == StWait) && !dmem_ready
                         && (waitCnt == LAST_CNT);
    assign stall       = busActive && !dmem_ready && !timeoutHit;
    assign StallM      = stall;

    always_comb begin
        fmtWdata = WriteDataM;
        fmtBe    = 4'b1111;
        case (Funct3M[1:0])
            2'b00: begin
                fmtWdata = {4{WriteDataM[7:0]}};
                fmtBe    = 4'b0001 << ALUResultM[1:0];
            end
            2'b01: begin
                fmtWdata = {2{WriteDataM[15:0]}};
                fmtBe    = 4'b0011 << ALUResultM[1:0];
            end
            default: begin
                fmtWdata = WriteDataM;
                fmtBe    = 4'b1111;
            end
        endcase
    end

    // While waiting the bus is driven only from the latched copies so it stays stable.
    always_comb begin
        dmem_req   = busActive;
        dmem_we    = 1'b0;
        dmem_addr  = 32'd0;
        dmem_wdata = 32'd0;
        dmem_be    = 4'b0000;
        if (state == StWait) begin
            dmem_we    = latWe;
            dmem_addr  = {latAddr[31:2], 2'b00};
            dmem_wdata = latWdata;
            dmem_be    = latBe;
        end else if (startAccess) begin
            dmem_we    = MemWriteM;
            dmem_addr  = {ALUResultM[31:2], 2'b00};
            dmem_wdata = fmtWdata;
            dmem_be    = fmtBe;
        end
    end

    assign laneSel   = (state == StWait) ? latAddr[1:0] : ALUResultM[1:0];
    assign curFunct3 = (state == StWait) ? latFunct3 : Funct3M;
    assign laneData  = dmem_rdata >> {laneSel, 3'b000};

    always_comb begin
        loadExt = laneData;
        case (curFunct3)
            3'b000:  loadExt = {{24{laneData[7]}}, laneData[7:0]};
            3'b001:  loadExt = {{16{laneData[15]}}, laneData[15:0]};
            3'b100:  loadExt = {24'd0, laneData[7:0]};
            3'b101:  loadExt = {16'd0, laneData[15:0]};
            default: loadExt = laneData;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            waitCnt    <= '0;
            latAddr    <= 32'd0;
            latWdata   <= 32'd0;
            latWe      <= 1'b0;
            latBe      <= 4'b0000;
            latFunct3  <= 3'b000;
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            ALUResultW <= 32'd0;
            ReadDataW  <= 32'd0;
            RdW        <= 5'd0;
            PCPlus4W   <= 32'd0;
            MisalignW  <= 1'b0;
            BusErrW    <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (startAccess && !dmem_ready) begin
                        state     <= StWait;
                        waitCnt   <= '0;
                        latAddr   <= ALUResultM;
                        latWdata  <= fmtWdata;
                        latWe     <= MemWriteM;
                        latBe     <= fmtBe;
                        latFunct3 <= Funct3M;
                    end
                end
                StWait: begin
                    if (dmem_ready || timeoutHit) begin
                        state   <= StIdle;
                        waitCnt <= '0;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        waitCnt <= waitCnt + CW'(1);
                    end
                end
            endcase

            // A stalled cycle pushes a bubble; payload fields keep their last value.
            if (stall) begin
                RegWriteW <= 1'b0;
                MisalignW <= 1'b0;
                BusErrW   <= 1'b0;
            end else begin
                RegWriteW  <= RegWriteM && !misalignNow && !timeoutHit;
                ResultSrcW <= ResultSrcM;
                ALUResultW <= ALUResultM;
                ReadDataW  <= loadExt;
                RdW        <= RdM;
                PCPlus4W   <= PCPlus4M;
                MisalignW  <= misalignNow;
                BusErrW    <= timeoutHit;
            end
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: directed scenarios plus randomized instruction stream vs. a transaction model.
module tb_memory_access_stage;

    localparam int TMO   = 4;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [4:0]  RdM;
    logic [31:0] PCPlus4M;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        StallM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [4:0]  RdW;
    logic [31:0] PCPlus4W;
    logic        MisalignW;
    logic        BusErrW;

    int nCmp = 0;
    int nBad = 0;

    always #5 clk = ~clk;

    memory_access_stage #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
        .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W), .MisalignW(MisalignW), .BusErrW(BusErrW)
    );

    typedef struct {
        bit          hung;
        int          stalls;
        bit          reqSeen;
        bit          reqBroken;
        bit          busUnstable;
        bit          beIdleBad;
        bit          bubbleBad;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        regW;
        logic [1:0]  rsrc;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic        mis;
        logic        berr;
        logic [2:0]  after;
        logic        reqAfter;
    } obs_t;

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] a);
        return (int'(a[1:0]) % size_of(f3)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int sz = size_of(f3);
        if (sz == 4) return 4'hF;
        return 4'(((1 << sz) - 1) << int'(a[1:0]));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        int sz = size_of(f3);
        if (sz == 1) return (d % 256) * 32'h0101_0101;
        if (sz == 2) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v = rd >> (8 * int'(a[1:0]));
        case (f3)
            3'b000: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            3'b001: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            3'b100: v = v % 256;
            3'b101: v = v % 65536;
            default: v = rd;
        endcase
        return v;
    endfunction

    // ---------------- stimulus driver: drives one instruction, records what the DUT did ----------------
    task automatic set_idle();
        RegWriteM = 1'b0; ResultSrcM = 2'b00; MemWriteM = 1'b0; Funct3M = 3'b000;
        ALUResultM = 32'd0; WriteDataM = 32'd0; RdM = 5'd0; PCPlus4M = 32'd0; dmem_ready = 1'b0;
    endtask

    task automatic run_op(input logic regWrite, input logic [1:0] rsrc, input logic memWrite,
                          input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd, input logic [31:0] pc4, input int readyAt,
                          input logic [31:0] rdata, output obs_t o);
        bit stalled;
        bit done;
        o = '{default: 0};
        done = 0;
        RegWriteM = regWrite; ResultSrcM = rsrc; MemWriteM = memWrite; Funct3M = f3;
        ALUResultM = addr; WriteDataM = wd; RdM = rd; PCPlus4M = pc4; dmem_rdata = rdata;
        for (int i = 0; i < 64; i++) begin
            dmem_ready = (i == readyAt);
            #1;
            if (dmem_req === 1'b1) begin
                if (!o.reqSeen) begin
                    o.reqSeen = 1; o.we = dmem_we; o.addr = dmem_addr; o.wdata = dmem_wdata; o.be = dmem_be;
                end else if ({dmem_we, dmem_addr, dmem_wdata, dmem_be} !== {o.we, o.addr, o.wdata, o.be}) begin
                    o.busUnstable = 1;
                end
            end else begin
                if (dmem_be !== 4'b0000) o.beIdleBad = 1;
                if (o.reqSeen) o.reqBroken = 1;
            end
            stalled = (StallM === 1'b1);
            if (stalled) o.stalls++;
            @(posedge clk); #1;
            if (!stalled) begin
                o.regW = RegWriteW; o.rsrc = ResultSrcW; o.alu = ALUResultW; o.rdata = ReadDataW;
                o.rd = RdW; o.pc4 = PCPlus4W; o.mis = MisalignW; o.berr = BusErrW;
                done = 1;
                break;
            end else if ({RegWriteW, MisalignW, BusErrW} !== 3'b000) begin
                o.bubbleBad = 1;
            end
        end
        if (!done) o.hung = 1;
        set_idle();
        #1;
        o.reqAfter = dmem_req;
        @(posedge clk); #1;
        o.after = {RegWriteW, MisalignW, BusErrW};
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        set_idle();
        dmem_rdata = 32'd0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        nCmp++; if ({RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W, MisalignW, BusErrW} !== '0) begin
            nBad++; $display("FAIL reset_w_outputs: got %h want 0", {RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W, MisalignW, BusErrW}); end
        nCmp++; if ({dmem_req, StallM, dmem_be} !== 6'd0) begin
            nBad++; $display("FAIL reset_bus: got req/stall/be %b want 000000", {dmem_req, StallM, dmem_be}); end
        rst = 1'b0;
    endtask

    task automatic test_lw_fast();
        obs_t o;
        run_op(1'b1, 2'b01, 1'b0, 3'b010, 32'h100, 32'd0, 5'd7, 32'h44, 0, 32'hDEAD_BEEF, o);
        nCmp++; if (o.stalls !== 0) begin nBad++; $display("FAIL lw_fast_stalls: got %0d want 0", o.stalls); end
        nCmp++; if (o.regW !== 1'b1) begin nBad++; $display("FAIL lw_fast_regw: got %b want 1", o.regW); end
        nCmp++; if (o.rdata !== 32'hDEAD_BEEF) begin nBad++; $display("FAIL lw_fast_data: got %h want deadbeef", o.rdata); end
        nCmp++; if ({o.we, o.addr, o.be} !== {1'b0, 32'h100, 4'hF}) begin
            nBad++; $display("FAIL lw_fast_bus: got we=%b addr=%h be=%b want 0/100/1111", o.we, o.addr, o.be); end
        nCmp++; if (o.rd !== 5'd7) begin nBad++; $display("FAIL lw_fast_rd: got %0d want 7", o.rd); end
    endtask

    task automatic test_lb_wait();
        obs_t o;
        run_op(1'b1, 2'b01, 1'b0, 3'b000, 32'h103, 32'd0, 5'd3, 32'h48, 3, 32'h8011_2233, o);
        nCmp++; if (o.stalls !== 3) begin nBad++; $display("FAIL lb_stalls: got %0d want 3", o.stalls); end
        nCmp++; if (o.rdata !== 32'hFFFF_FF80) begin nBad++; $display("FAIL lb_data: got %h want ffffff80", o.rdata); end
        nCmp++; if (o.be !== 4'b1000) begin nBad++; $display("FAIL lb_be: got %b want 1000", o.be); end
        nCmp++; if (o.busUnstable || o.bubbleBad) begin
            nBad++; $display("FAIL lb_wait_hold: got unstable=%0d bubblebad=%0d want 0/0", o.busUnstable, o.bubbleBad); end
        run_op(1'b1, 2'b01, 1'b0, 3'b100, 32'h103, 32'd0, 5'd3, 32'h4C, 3, 32'h8011_2233, o);
        nCmp++; if (o.rdata !== 32'h0000_0080) begin nBad++; $display("FAIL lbu_data: got %h want 00000080", o.rdata); end
    endtask

    task automatic test_sh();
        obs_t o;
        run_op(1'b0, 2'b00, 1'b1, 3'b001, 32'h2, 32'h1234_ABCD, 5'd0, 32'h50, 0, 32'd0, o);
        nCmp++; if (o.we !== 1'b1) begin nBad++; $display("FAIL sh_we: got %b want 1", o.we); end
        nCmp++; if (o.be !== 4'b1100) begin nBad++; $display("FAIL sh_be: got %b want 1100", o.be); end
        nCmp++; if (o.wdata !== 32'hABCD_ABCD) begin nBad++; $display("FAIL sh_wdata: got %h want abcdabcd", o.wdata); end
        nCmp++; if (o.regW !== 1'b0) begin nBad++; $display("FAIL sh_regw: got %b want 0", o.regW); end
    endtask

    task automatic test_misalign();
        obs_t o;
        run_op(1'b1, 2'b01, 1'b0, 3'b010, 32'h102, 32'd0, 5'd9, 32'h54, 0, 32'h1111_1111, o);
        nCmp++; if (o.reqSeen !== 1'b0) begin nBad++; $display("FAIL mis_req: got %b want 0", o.reqSeen); end
        nCmp++; if ({o.mis, o.regW} !== 2'b10) begin nBad++; $display("FAIL mis_flags: got mis/regw %b want 10", {o.mis, o.regW}); end
        nCmp++; if (o.after !== 3'b000) begin nBad++; $display("FAIL mis_one_cycle: got %b want 000", o.after); end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_op(1'b1, 2'b01, 1'b0, 3'b010, 32'h200, 32'd0, 5'd4, 32'h58, NEVER, 32'h5555_AAAA, o);
        nCmp++; if (o.hung !== 1'b0) begin nBad++; $display("FAIL tmo_hung: got %b want 0", o.hung); end
        nCmp++; if (o.stalls !== TMO) begin nBad++; $display("FAIL tmo_stalls: got %0d want %0d", o.stalls, TMO); end
        nCmp++; if ({o.berr, o.regW} !== 2'b10) begin nBad++; $display("FAIL tmo_flags: got berr/regw %b want 10", {o.berr, o.regW}); end
        nCmp++; if ({o.after, o.reqAfter} !== 4'b0000) begin
            nBad++; $display("FAIL tmo_after: got flags %b req %b want 000 0", o.after, o.reqAfter); end
        run_op(1'b1, 2'b01, 1'b0, 3'b010, 32'h204, 32'd0, 5'd4, 32'h5C, TMO, 32'h0BAD_F00D, o);
        nCmp++; if ({o.berr, o.regW} !== 2'b01) begin nBad++; $display("FAIL tmo_ready_wins: got berr/regw %b want 01", {o.berr, o.regW}); end
        nCmp++; if (o.rdata !== 32'h0BAD_F00D) begin nBad++; $display("FAIL tmo_ready_data: got %h want 0badf00d", o.rdata); end
    endtask

    task automatic test_reset_in_wait();
        obs_t o;
        RegWriteM = 1'b1; ResultSrcM = 2'b01; MemWriteM = 1'b0; Funct3M = 3'b010;
        ALUResultM = 32'h300; RdM = 5'd12; PCPlus4M = 32'h60; dmem_ready = 1'b0;
        #1;
        nCmp++; if ({dmem_req, StallM} !== 2'b11) begin nBad++; $display("FAIL rstw_pre: got req/stall %b want 11", {dmem_req, StallM}); end
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        set_idle();
        @(posedge clk); #1;
        nCmp++; if ({dmem_req, StallM} !== 2'b00) begin nBad++; $display("FAIL rstw_bus: got req/stall %b want 00", {dmem_req, StallM}); end
        nCmp++; if ({RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W, MisalignW, BusErrW} !== '0) begin
            nBad++; $display("FAIL rstw_w_outputs: got %h want 0", {RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W, MisalignW, BusErrW}); end
        rst = 1'b0;
        run_op(1'b1, 2'b01, 1'b0, 3'b010, 32'h304, 32'd0, 5'd13, 32'h64, 1, 32'h1234_5678, o);
        nCmp++; if ({o.regW, o.berr, o.rdata} !== {2'b10, 32'h1234_5678}) begin
            nBad++; $display("FAIL rstw_next_lw: got regw=%b berr=%b data=%h want 1/0/12345678", o.regW, o.berr, o.rdata); end
        nCmp++; if (o.stalls !== 1) begin nBad++; $display("FAIL rstw_next_stalls: got %0d want 1", o.stalls); end
    endtask

    task automatic test_random();
        obs_t o;
        for (int n = 0; n < 200; n++) begin
            int kind = $urandom_range(0, 2);
            int r = $urandom_range(0, 7);
            int readyAt = (r == 7) ? NEVER : r;
            logic [2:0] ldF3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            logic regWrite, memWrite, access, expMis, expErr;
            logic [1:0] rsrc;
            logic [2:0] f3;
            logic [31:0] addr = $urandom, wd = $urandom, pc4 = $urandom, rdata = $urandom;
            logic [4:0] rd = 5'($urandom);
            int expStalls;
            if (kind == 0) begin
                rsrc = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10; memWrite = 1'b0;
                regWrite = 1'($urandom); f3 = 3'($urandom);
            end else if (kind == 1) begin
                rsrc = 2'b01; memWrite = 1'b0; regWrite = 1'b1; f3 = ldF3[$urandom_range(0, 4)];
            end else begin
                rsrc = 2'b00; memWrite = 1'b1; regWrite = 1'b0; f3 = 3'($urandom_range(0, 2));
            end
            access    = (kind != 0);
            expMis    = access && model_misaligned(f3, addr);
            expErr    = access && !expMis && (readyAt > TMO);
            expStalls = (access && !expMis) ? ((readyAt < TMO) ? readyAt : TMO) : 0;
            run_op(regWrite, rsrc, memWrite, f3, addr, wd, rd, pc4, readyAt, rdata, o);
            nCmp++; if (o.hung !== 1'b0) begin nBad++; $display("FAIL rnd_hung[%0d]: got %b want 0", n, o.hung); end
            nCmp++; if (o.stalls !== expStalls) begin nBad++; $display("FAIL rnd_stalls[%0d]: got %0d want %0d", n, o.stalls, expStalls); end
            nCmp++; if (o.reqSeen !== (access && !expMis)) begin nBad++; $display("FAIL rnd_req[%0d]: got %b want %b", n, o.reqSeen, access && !expMis); end
            nCmp++; if ({o.busUnstable, o.beIdleBad, o.bubbleBad, o.reqBroken} !== 4'b0000) begin
                nBad++; $display("FAIL rnd_protocol[%0d]: got unstable/beidle/bubble/reqdrop %b want 0000", n, {o.busUnstable, o.beIdleBad, o.bubbleBad, o.reqBroken}); end
            if (access && !expMis) begin
                nCmp++; if ({o.we, o.addr, o.be} !== {memWrite, addr[31:2], 2'b00, model_be(f3, addr)}) begin
                    nBad++; $display("FAIL rnd_bus[%0d]: got we=%b addr=%h be=%b want %b/%h/%b", n, o.we, o.addr, o.be, memWrite, {addr[31:2], 2'b00}, model_be(f3, addr)); end
                if (memWrite) begin
                    nCmp++; if (o.wdata !== model_wdata(f3, wd)) begin
                        nBad++; $display("FAIL rnd_wdata[%0d]: got %h want %h", n, o.wdata, model_wdata(f3, wd)); end
                end else if (!expErr) begin
                    nCmp++; if (o.rdata !== model_load(f3, addr, rdata)) begin
                        nBad++; $display("FAIL rnd_load[%0d]: got %h want %h", n, o.rdata, model_load(f3, addr, rdata)); end
                end
            end
            nCmp++; if ({o.regW, o.mis, o.berr} !== {regWrite && !expMis && !expErr, expMis, expErr}) begin
                nBad++; $display("FAIL rnd_flags[%0d]: got regw/mis/berr %b want %b", n, {o.regW, o.mis, o.berr}, {regWrite && !expMis && !expErr, expMis, expErr}); end
            nCmp++; if ({o.rsrc, o.alu, o.rd, o.pc4} !== {rsrc, addr, rd, pc4}) begin
                nBad++; $display("FAIL rnd_payload[%0d]: got %h want %h", n, {o.rsrc, o.alu, o.rd, o.pc4}, {rsrc, addr, rd, pc4}); end
            nCmp++; if (o.after !== 3'b000) begin nBad++; $display("FAIL rnd_after[%0d]: got %b want 000", n, o.after); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", nCmp);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lw_fast();
        test_lb_wait();
        test_sh();
        test_misalign();
        test_timeout();
        test_reset_in_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
